// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int XLEN          = 32;
  localparam int ITERS_DEFAULT = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Operand magnitude extraction on issue and sign restoration of the
// 64-bit product or the 32-bit quotient/remainder pair on completion.
module mdu_signfix
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0]   rs_i,
  input  logic [XLEN-1:0]   rt_i,
  input  logic              abs_en_i,
  output logic [XLEN-1:0]   rs_mag_o,
  output logic [XLEN-1:0]   rt_mag_o,
  input  logic [2*XLEN-1:0] res_i,
  input  logic              neg_wide_i,
  input  logic              neg_hi_i,
  input  logic              neg_lo_i,
  output logic [2*XLEN-1:0] res_o
);

  assign rs_mag_o = (abs_en_i && rs_i[XLEN-1]) ? -rs_i : rs_i;
  assign rt_mag_o = (abs_en_i && rt_i[XLEN-1]) ? -rt_i : rt_i;

  // A product negates as one 64-bit value; quotient and remainder negate independently.
  always_comb begin
    // NOTE: default assignment first so every path drives res_o and no latch is inferred.
    res_o = res_i;
    if (neg_wide_i) begin
      res_o = -res_i;
    end else begin
      if (neg_hi_i) res_o[2*XLEN-1:XLEN] = -res_i[2*XLEN-1:XLEN];
      if (neg_lo_i) res_o[XLEN-1:0]      = -res_i[XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: multiply exits as soon as the remaining multiplier bits are zero.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] Rs,
  input  logic [XLEN-1:0] Rt,
  output logic            Busy,
  output logic            Done,
  output logic            DivZero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int CW = $clog2(ITERS + 1);

  mdu_state_e        state_q;
  logic              busy_q, done_q, divzero_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [CW-1:0]     count_q;
  logic              is_div_q, neg_prod_q, neg_quo_q, neg_rem_q;
`ifdef MDU_EARLY_OUT_EN
  logic [XLEN-1:0]   mrem_q;
`endif

  logic              op_mul, op_div, op_sgn, div_zero;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, iter_next;
  logic [2*XLEN-1:0] fix_raw, fix_res;
  logic              last_iter;

  assign op_mul   = op_is_mul(Op);
  assign op_div   = op_is_div(Op);
  assign op_sgn   = op_is_signed(Op);
  assign div_zero = op_div && (Rt == '0);

  mdu_signfix u_signfix (
    .rs_i       (Rs),
    .rt_i       (Rt),
    .abs_en_i   (op_sgn),
    .rs_mag_o   (rs_mag),
    .rt_mag_o   (rt_mag),
    .res_i      (fix_raw),
    .neg_wide_i (neg_prod_q),
    .neg_hi_i   (neg_rem_q),
    .neg_lo_i   (neg_quo_q),
    .res_o      (fix_res)
  );

  // acc_q holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_trial = div_shift - {1'b0, opnd_q};
    div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    iter_next = is_div_q ? div_next : mul_next;
  end

`ifdef MDU_EARLY_OUT_EN
  // The shifts skipped by an early exit are applied to the product in FIX.
  assign last_iter = (count_q == CW'(ITERS - 1)) ||
                     (!is_div_q && (mrem_q[XLEN-1:1] == '0));
  assign fix_raw   = is_div_q ? acc_q : (acc_q >> (CW'(ITERS) - count_q));
`else
  assign last_iter = (count_q == CW'(ITERS - 1));
  assign fix_raw   = acc_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      divzero_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
      mrem_q     <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (div_zero) begin
              done_q    <= 1'b1;
              divzero_q <= 1'b1;
            end else if (op_mul || op_div) begin
              state_q    <= CALC;
              busy_q     <= 1'b1;
              count_q    <= '0;
              is_div_q   <= op_div;
              acc_q      <= {{XLEN{1'b0}}, (op_div ? rs_mag : rt_mag)};
              opnd_q     <= op_div ? rt_mag : rs_mag;
              neg_prod_q <= op_mul && op_sgn && (Rs[XLEN-1] ^ Rt[XLEN-1]);
              neg_quo_q  <= op_div && op_sgn && (Rs[XLEN-1] ^ Rt[XLEN-1]);
              neg_rem_q  <= op_div && op_sgn && Rs[XLEN-1];
`ifdef MDU_EARLY_OUT_EN
              mrem_q     <= rt_mag;
`endif
            end else if (Op == MDU_MTHI) begin
              hi_q   <= Rs;
              done_q <= 1'b1;
            end else if (Op == MDU_MTLO) begin
              lo_q   <= Rs;
              done_q <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q   <= iter_next;
          count_q <= count_q + CW'(1);
`ifdef MDU_EARLY_OUT_EN
          mrem_q  <= mrem_q >> 1;
`endif
          if (last_iter) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_res[2*XLEN-1:XLEN];
          lo_q    <= fix_res[XLEN-1:0];
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_hilo;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI  = 3'd4, OP_MTLO = 3'd5;

  logic        CLK, RST, Start;
  logic [2:0]  Op;
  logic [31:0] Rs, Rt;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  mdu_hilo dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .Rs(Rs), .Rt(Rt),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Reference results from plain arithmetic: returns the new {HI,LO}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] hi, lo);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) return {hi, lo};
        q = sa / sb; r = sa % sb; qv = 64'(q); rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      OP_DIVU:  return (b == 0) ? {hi, lo} : {a % b, a / b};
      OP_MTHI:  return {a, lo};
      OP_MTLO:  return {hi, a};
      default:  return {hi, lo};
    endcase
  endfunction

  // Edges from the accept edge (inclusive) until Done is visible.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
    int top;
`endif
    if (op == OP_MTHI || op == OP_MTLO) return 1;
    if (op == OP_DIV || op == OP_DIVU) return (b == 0) ? 1 : 34;
    if (op != OP_MULT && op != OP_MULTU) return 0;
`ifdef MDU_EARLY_OUT_EN
    m = (op == OP_MULT && b[31]) ? -b : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i + 1;
    return 2 + ((top == 0) ? 1 : top);
`else
    return 34;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where Done is seen (or the bound expires).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                        output int lat, output int busy_n, output int hold_bad);
    logic [31:0] hi0, lo0;
    hi0 = HI; lo0 = LO;
    Start = 1'b1; Op = op; Rs = a; Rt = b;
    @(posedge CLK);
    lat = 1; busy_n = 0; hold_bad = 0;
    @(negedge CLK);
    Start = 1'b0;
    while (Done !== 1'b1 && lat < 120) begin
      if (Busy === 1'b1) busy_n++;
      if (HI !== hi0 || LO !== lo0) hold_bad++;
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b0; Op = 3'd0; Rs = '0; Rt = '0;
    #12;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", Busy); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b expected 0", Done); end
    vectors++; if (DivZero !== 1'b0) begin miscompares++; $display("FAIL reset divzero: got %b expected 0", DivZero); end
    vectors++; if (HI !== 32'd0) begin miscompares++; $display("FAIL reset hi: got %h expected 0", HI); end
    vectors++; if (LO !== 32'd0) begin miscompares++; $display("FAIL reset lo: got %h expected 0", LO); end
    @(negedge CLK);
    RST = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_multu_max();
    int lat, bn, hb;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn, hb);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL multu_max latency: got %0d expected 34", lat); end
    vectors++; if (bn !== 33) begin miscompares++; $display("FAIL multu_max busy_cycles: got %0d expected 33", bn); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL multu_max busy_at_done: got %b expected 0", Busy); end
    vectors++; if (hb !== 0) begin miscompares++; $display("FAIL multu_max hilo_hold: got %0d changes expected 0", hb); end
    vectors++; if (HI !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_max hi: got %h expected fffffffe", HI); end
    vectors++; if (LO !== 32'h00000001) begin miscompares++; $display("FAIL multu_max lo: got %h expected 00000001", LO); end
    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
  endtask

  task automatic test_mult_signed();
    int lat, bn, hb, el;
    el = exp_lat(OP_MULT, 32'd7);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bn, hb);
    vectors++; if (lat !== el) begin miscompares++; $display("FAIL mult_signed latency: got %0d expected %0d", lat, el); end
    vectors++; if (HI !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_signed hi: got %h expected ffffffff", HI); end
    vectors++; if (LO !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_signed lo: got %h expected ffffffeb", LO); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB;
  endtask

  task automatic test_div_signed();
    int lat, bn, hb;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bn, hb);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL div_signed latency: got %0d expected 34", lat); end
    vectors++; if (LO !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_signed lo: got %h expected fffffffd", LO); end
    vectors++; if (HI !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_signed hi: got %h expected ffffffff", HI); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
  endtask

  task automatic test_div_overflow();
    int lat, bn, hb;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bn, hb);
    vectors++; if (DivZero !== 1'b0) begin miscompares++; $display("FAIL div_ovf divzero: got %b expected 0", DivZero); end
    vectors++; if (LO !== 32'h80000000) begin miscompares++; $display("FAIL div_ovf lo: got %h expected 80000000", LO); end
    vectors++; if (HI !== 32'd0) begin miscompares++; $display("FAIL div_ovf hi: got %h expected 0", HI); end
    m_hi = 32'd0; m_lo = 32'h80000000;
  endtask

  task automatic test_divzero_moves();
    int lat, bn, hb;
    run_op(OP_MTHI, 32'h1234, 32'd0, lat, bn, hb);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mthi latency: got %0d expected 1", lat); end
    run_op(OP_MTLO, 32'h5678, 32'd0, lat, bn, hb);
    vectors++; if (HI !== 32'h1234) begin miscompares++; $display("FAIL mthi hi: got %h expected 00001234", HI); end
    run_op(OP_DIVU, 32'd99, 32'd0, lat, bn, hb);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL divzero latency: got %0d expected 1", lat); end
    vectors++; if (DivZero !== 1'b1) begin miscompares++; $display("FAIL divzero flag: got %b expected 1", DivZero); end
    vectors++; if (bn !== 0 || Busy !== 1'b0) begin miscompares++; $display("FAIL divzero busy: got %0d/%b expected 0/0", bn, Busy); end
    vectors++; if (HI !== 32'h1234) begin miscompares++; $display("FAIL divzero hi: got %h expected 00001234", HI); end
    vectors++; if (LO !== 32'h5678) begin miscompares++; $display("FAIL divzero lo: got %h expected 00005678", LO); end
    @(posedge CLK); @(negedge CLK);
    vectors++; if (Done !== 1'b0 || DivZero !== 1'b0) begin miscompares++; $display("FAIL divzero pulse: got %b/%b expected 0/0", Done, DivZero); end
    m_hi = 32'h1234; m_lo = 32'h5678;
  endtask

  task automatic test_ignored_op();
    int bad;
    for (int k = 6; k <= 7; k++) begin
      bad = 0;
      Start = 1'b1; Op = 3'(k); Rs = $urandom(); Rt = $urandom();
      @(posedge CLK); @(negedge CLK);
      Start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (Done !== 1'b0 || Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) bad++;
        @(posedge CLK); @(negedge CLK);
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ignored_op%0d: got %0d bad cycles expected 0", k, bad); end
    end
  endtask

  task automatic test_abort();
    int lat, bn, hb, bad;
    bad = 0;
    Start = 1'b1; Op = OP_DIVU; Rs = 32'd100; Rt = 32'd7;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) Start = 1'b0;
      if (cyc == 5) begin Start = 1'b1; Op = OP_MTHI; Rs = 32'hDEAD; end
      if (cyc == 6) Start = 1'b0;
      if (Busy !== 1'b1 || Done !== 1'b0 || HI !== m_hi || LO !== m_lo) bad++;
      @(posedge CLK);
    end
    @(negedge CLK);
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL abort busy_window: got %0d bad cycles expected 0", bad); end
    RST = 1'b0;
    #1;
    vectors++; if (HI !== 32'd0 || LO !== 32'd0) begin miscompares++; $display("FAIL abort async_clear: got %h/%h expected 0/0", HI, LO); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL abort busy_clear: got %b expected 0", Busy); end
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge CLK); @(negedge CLK);
    vectors++; if (Busy !== 1'b0 || Done !== 1'b0) begin miscompares++; $display("FAIL abort no_resume: got %b/%b expected 0/0", Busy, Done); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bn, hb);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL abort redo latency: got %0d expected 34", lat); end
    vectors++; if (LO !== 32'd14) begin miscompares++; $display("FAIL abort redo lo: got %0d expected 14", LO); end
    vectors++; if (HI !== 32'd2) begin miscompares++; $display("FAIL abort redo hi: got %0d expected 2", HI); end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  // The second request is driven in the cycle where the first one's Done is high.
  task automatic test_back_to_back();
    int lat, bn, hb;
    run_op(OP_MULTU, 32'h00010000, 32'h00010003, lat, bn, hb);
    run_op(OP_DIVU, 32'd1000, 32'd33, lat, bn, hb);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL b2b latency: got %0d expected 34", lat); end
    vectors++; if (hb !== 0) begin miscompares++; $display("FAIL b2b hilo_hold: got %0d changes expected 0", hb); end
    vectors++; if (LO !== 32'd30 || HI !== 32'd10) begin miscompares++; $display("FAIL b2b result: got %0d/%0d expected 30/10", LO, HI); end
    run_op(OP_MTLO, 32'hCAFE, 32'd0, lat, bn, hb);
    vectors++; if (lat !== 1 || LO !== 32'hCAFE || HI !== 32'd10) begin miscompares++; $display("FAIL b2b mtlo: got lat %0d lo %h hi %h expected 1/cafe/a", lat, LO, HI); end
    m_hi = 32'd10; m_lo = 32'hCAFE;
  endtask

  task automatic test_random();
    int lat, bn, hb, el, eb;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    logic        ez;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = pick();
      b  = pick();
      e  = model(op, a, b, m_hi, m_lo);
      el = exp_lat(op, b);
      eb = (el > 1) ? el - 1 : 0;
      ez = (op == OP_DIV || op == OP_DIVU) && (b == 0);
      run_op(op, a, b, lat, bn, hb);
      vectors++; if (lat !== el) begin miscompares++; $display("FAIL rand[%0d] op%0d latency: got %0d expected %0d", i, op, lat, el); end
      vectors++; if (bn !== eb) begin miscompares++; $display("FAIL rand[%0d] op%0d busy_cycles: got %0d expected %0d", i, op, bn, eb); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rand[%0d] busy_at_done: got %b expected 0", i, Busy); end
      vectors++; if (hb !== 0) begin miscompares++; $display("FAIL rand[%0d] hilo_hold: got %0d changes expected 0", i, hb); end
      vectors++; if (DivZero !== ez) begin miscompares++; $display("FAIL rand[%0d] divzero: got %b expected %b", i, DivZero, ez); end
      vectors++; if (HI !== e[63:32]) begin miscompares++; $display("FAIL rand[%0d] op%0d a=%h b=%h hi: got %h expected %h", i, op, a, b, HI, e[63:32]); end
      vectors++; if (LO !== e[31:0]) begin miscompares++; $display("FAIL rand[%0d] op%0d a=%h b=%h lo: got %h expected %h", i, op, a, b, LO, e[31:0]); end
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_div_overflow();
    test_divzero_moves();
    test_ignored_op();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
